// File: rtl/down_counter_seq.sv
// down_counter_seq: loadable down-counter sequencer with one-cycle done pulse.
// Optional DOWN_COUNTER_SEQ_AUTORELOAD_EN restarts from the last loaded count after each done.
module down_counter_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             tc
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_step;

    assign last_step = busy_q && en && (out_q == WIDTH'(1));
`ifdef DOWN_COUNTER_SEQ_AUTORELOAD_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
`ifdef DOWN_COUNTER_SEQ_AUTORELOAD_EN
        shadow_d = shadow_q;
`endif
        if (state_q == RUN) begin
            if (abort) begin
                state_d = IDLE;
                out_d   = '0;
            end else if (last_step) begin
                state_d = DONE;
                out_d   = '0;
            end else if (en && out_q != '0) begin
                out_d = out_q - WIDTH'(1);
            end
        end else if (start) begin
            out_d   = in;
            state_d = (in != '0) ? RUN : DONE;
`ifdef DOWN_COUNTER_SEQ_AUTORELOAD_EN
            shadow_d = in;
`endif
        end else if (state_q == DONE) begin
`ifdef DOWN_COUNTER_SEQ_AUTORELOAD_EN
            out_d   = shadow_q;
            state_d = (shadow_q != '0) ? RUN : IDLE;
`else
            state_d = IDLE;
`endif
        end
        // busy/done are registered copies of the next state so they stay glitch-free
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DOWN_COUNTER_SEQ_AUTORELOAD_EN
            shadow_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DOWN_COUNTER_SEQ_AUTORELOAD_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign tc   = last_step;
endmodule

// File: tb/tb_down_counter_seq.sv
// tb_down_counter_seq: table-driven directed vectors plus hand sequences for reset and reload.
module tb_down_counter_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = '0;
    logic       en = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] out;
    logic       busy, done, tc;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string name;
        int s, i, e, a, o, b, d, t;
    } vec_t;
    vec_t vecs[$];

    down_counter_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(din), .en(en),
        .abort(abort), .out(out), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string n, input int s, input int i, input int e, input int a,
                       input int o, input int b, input int d, input int t);
        vec_t v;
        v.name = n; v.s = s; v.i = i; v.e = e; v.a = a;
        v.o = o; v.b = b; v.d = d; v.t = t;
        vecs.push_back(v);
    endtask

    task automatic drive(input int s, input int i, input int e, input int a);
        @(negedge clk);
        start = s[0];
        din   = i[7:0];
        en    = e[0];
        abort = a[0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string n, input int o, input int b, input int d, input int t);
        check({n, ".out"}, int'(out), o);
        check({n, ".busy"}, int'(busy), b);
        check({n, ".done"}, int'(done), d);
        check({n, ".tc"}, int'(tc), t);
    endtask

    initial begin
        #2;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        add("idle_abort",   0, 0,   0, 1, 0,   0, 0, 0);
        add("t2_load",      1, 3,   1, 0, 3,   1, 0, 0);
        add("t2_s1",        0, 0,   1, 0, 2,   1, 0, 0);
        add("t2_s2",        0, 0,   1, 0, 1,   1, 0, 1);
        add("t2_done",      0, 0,   1, 0, 0,   0, 1, 0);
        add("t2_idle",      0, 0,   1, 0, 0,   0, 0, 0);
        add("t3_zero",      1, 0,   0, 0, 0,   0, 1, 0);
        add("t3_idle",      0, 0,   0, 0, 0,   0, 0, 0);
        add("t4_load",      1, 2,   0, 0, 2,   1, 0, 0);
        add("t4_e1",        0, 0,   1, 0, 1,   1, 0, 1);
        add("t4_e0a",       0, 0,   0, 0, 1,   1, 0, 0);
        add("t4_e0b",       0, 0,   0, 0, 1,   1, 0, 0);
        add("t4_e1b",       0, 0,   1, 0, 0,   0, 1, 0);
        add("t4_idle",      0, 0,   0, 0, 0,   0, 0, 0);
        add("t5_load",      1, 9,   1, 0, 9,   1, 0, 0);
        add("t5_8",         0, 0,   1, 0, 8,   1, 0, 0);
        add("t5_start_run", 1, 4,   1, 0, 7,   1, 0, 0);
        add("t5_6",         0, 0,   1, 0, 6,   1, 0, 0);
        add("t5_5",         0, 0,   1, 0, 5,   1, 0, 0);
        add("t5_abort",     0, 0,   1, 1, 0,   0, 0, 0);
        add("t5_idle",      0, 0,   0, 0, 0,   0, 0, 0);
        add("t6_load",      1, 2,   1, 0, 2,   1, 0, 0);
        add("t6_s1",        0, 0,   1, 0, 1,   1, 0, 1);
        add("t6_done",      0, 0,   1, 0, 0,   0, 1, 0);
        add("t6_b2b",       1, 5,   1, 0, 5,   1, 0, 0);
        add("t6_4",         0, 0,   1, 0, 4,   1, 0, 0);
        add("t6_abort",     0, 0,   0, 1, 0,   0, 0, 0);
        add("max_load",     1, 255, 0, 0, 255, 1, 0, 0);
        add("max_dec",      0, 0,   1, 0, 254, 1, 0, 0);
        add("max_abort",    0, 0,   1, 1, 0,   0, 0, 0);
        add("d_load",       1, 1,   1, 0, 1,   1, 0, 1);
        add("d_step",       0, 0,   1, 0, 0,   0, 1, 0);
        add("d_abort_done", 1, 6,   0, 1, 6,   1, 0, 0);
        add("d_abort",      0, 0,   0, 1, 0,   0, 0, 0);

`ifndef DOWN_COUNTER_SEQ_AUTORELOAD_EN
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].s, vecs[k].i, vecs[k].e, vecs[k].a);
            check_all(vecs[k].name, vecs[k].o, vecs[k].b, vecs[k].d, vecs[k].t);
        end
`else
        // start in=2 with en high: done every third cycle until abort
        drive(1, 2, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            drive(0, 0, 1, 0);
            check($sformatf("reload_done%0d", k), int'(done), (k % 3 == 2) ? 1 : 0);
            check($sformatf("reload_out%0d", k), int'(out), (k % 3 == 0) ? 2 : (k % 3 == 1) ? 1 : 0);
        end
        drive(0, 0, 1, 1);
        check_all("reload_abort", 0, 0, 0, 0);
        drive(0, 0, 1, 0);
        check_all("reload_idle", 0, 0, 0, 0);
`endif

        // asynchronous reset in the middle of a run at out=7
        drive(1, 9, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        check("rst_pre.out", int'(out), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, 0);
            check($sformatf("rst_nodone%0d", k), int'(done), 0);
            check($sformatf("rst_nobusy%0d", k), int'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
